opr1_sequencer: RTL and testbench
=================================

Name: opr1_sequencer

Overview:
- Multi-cycle sequencer for PDP-8 Operate Group 1 microinstructions.
- Accepts an OPR1 instruction plus the current AC/Link. Steps through the four PDP-8 micro-phases in architectural order: clear, complement, increment, rotate.
- Drives the existing combinational rotate/swap unit: supplies its OP code and operands, consumes its result.
- Returns the updated AC/L with a one-cycle write strobe. It is the control-side counterpart of the rotate unit, sitting between the instruction decoder and the AC/L registers.

Parameters:
- none (PDP-8 word width fixed at 12)

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle request; sampled only in IDLE
- IR  in  12  instruction word, sampled with START
- ACI  in  12  AC value, sampled with START
- LI  in  1  Link value, sampled with START
- ROT_OP  out  3  OP code to rotate unit; 000 outside phase T4
- ROT_OE  out  1  rotate unit output enable; high only in T4
- ROT_AC  out  12  working AC presented to rotate unit AI
- ROT_L  out  1  working Link presented to rotate unit LI
- ROT_AO  in  12  rotate unit AO result (combinational, same cycle)
- ROT_LO  in  1  rotate unit LO result
- BUSY  out  1  high from cycle after accepted START until DONE cycle inclusive
- DONE  out  1  one-cycle pulse; ACO/LO/WE valid
- WE  out  1  AC/L write enable, identical to DONE
- ACO  out  12  result AC, held until next accepted START
- LO  out  1  result Link, held until next accepted START

Behaviour:
- Reset: state IDLE; BUSY/DONE/WE/ROT_OE=0; ROT_OP=000; ACO=0; LO=0; working regs=0.
- Valid OPR1 means IR[11:8]=1110. START with any other IR, or while not IDLE, is ignored: no state change, no DONE.
- Accepted START latches IR[7:0], ACI, LI into working regs; next state T1.
- States: IDLE -> T1 -> T2 -> T3 -> T4 -> DN -> IDLE. Fixed length regardless of which bits are set.
- Timing: START accepted at edge N gives DONE high in cycle N+5.
- T1: IR7 (CLA) sets AC=0; IR6 (CLL) sets L=0.
- T2: IR5 (CMA) sets AC=~AC; IR4 (CML) sets L=~L.
- T3: IR0 (IAC) sets {L,AC} per 12-bit increment. Carry out of AC bit 11 complements L. Example: AC=7777, L=0 gives AC=0000, L=1.
- T4 ROT_OP derives from IR3 (RAR), IR2 (RAL), IR1 (BSW/twice):
  - RAL only = 010
  - RAL+IR1 = 011
  - RAR only = 100
  - RAR+IR1 = 101
  - IR1 only = 001 (swap)
  - RAR+RAL (any IR1) = 000 (no rotate, defined)
  - none = 000
- T4 actions: ROT_OE=1; working AC/L are loaded from ROT_AO/ROT_LO on the edge ending T4.
- DN: ACO/LO load working regs; DONE=WE=1 for exactly one cycle; return to IDLE. START is not sampled in DN.
- ROT_AC/ROT_L always mirror the working regs.
- RESET mid-sequence: immediate return to IDLE, no DONE/WE, ACO/LO cleared.
- All octal values below are 12-bit.

Decomposition:
- Shared package (opr_pkg): state encoding (IDLE,T1,T2,T3,T4,DN); IR bit index constants (CLA=7, CLL=6, CMA=5, CML=4, RAR=3, RAL=2, BSW=1, IAC=0); ROT_OP codes (NONE=000, SWAP=001, RAL=010, RTL=011, RAR=100, RTR=101).
- One natural sub-module: opr1_rotop_decode, a combinational IR[3:1] to ROT_OP mapping reusable by the decoder.
- Bench instantiates the real rotate unit wired to the ROT_* ports.

Test Plan:
- IR=7001 (IAC), ACI=1234, LI=0, START at cycle 0 -> DONE/WE high only in cycle 5; ACO=1235, LO=0; BUSY high cycles 1-5.
- IR=7001, ACI=7777, LI=0 -> ACO=0000, LO=1. Then IR=7360 (CLA CLL CMA CML), ACI=1234, LI=0 -> ACO=7777, LO=1.
- IR=7004 (RAL), ACI=4000, LI=0 -> ACO=0000, LO=1. Check ROT_OP=010 and ROT_OE=1 in T4 only.
- IR=7002 (BSW), ACI=1234 -> ACO=3412. IR=7012 (RTR), ACI=0001, LI=0 -> ACO=4000, LO=0, ROT_OP=101.
- IR=7205 (CLA IAC RAL), ACI=5555, LI=0 -> ACO=0002, LO=0. IR=7014 (RAR+RAL) -> AC/L unchanged.
- Protocol/reset checks:
  - START with IR=5000 -> ignored.
  - Second START in T2 -> ignored, single DONE.
  - RESET asserted in T3 -> no DONE, ACO=0, IDLE next cycle; fresh START then completes normally.

Source files
------------

// File: rtl/opr_pkg.sv
// Shared definitions for the PDP-8 Operate Group 1 sequencer: phase
// encoding, IR bit positions and the OP codes understood by the rotate unit.
package opr_pkg;

    localparam int WORD_W = 12;

    // Instruction field that identifies an OPR Group 1 word (IR[11:8]).
    localparam logic [3:0] OPR1_OPCODE = 4'b1110;

    // Micro-phase encoding, in architectural order.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_DN   = 3'd5
    } state_e;

    // Bit positions of the microinstructions inside IR[7:0].
    localparam int IR_CLA = 7;
    localparam int IR_CLL = 6;
    localparam int IR_CMA = 5;
    localparam int IR_CML = 4;
    localparam int IR_RAR = 3;
    localparam int IR_RAL = 2;
    localparam int IR_BSW = 1;
    localparam int IR_IAC = 0;

    // OP codes driven to the combinational rotate/swap unit.
    localparam logic [2:0] ROT_NONE = 3'b000;
    localparam logic [2:0] ROT_SWAP = 3'b001;
    localparam logic [2:0] ROT_RAL  = 3'b010;
    localparam logic [2:0] ROT_RTL  = 3'b011;
    localparam logic [2:0] ROT_RAR  = 3'b100;
    localparam logic [2:0] ROT_RTR  = 3'b101;

    // True when the instruction word belongs to Operate Group 1.
    function automatic logic is_opr1(input logic [WORD_W-1:0] ir);
        return ir[11:8] == OPR1_OPCODE;
    endfunction

endpackage

// File: rtl/opr1_rotop_decode.sv
// Maps the rotate field IR[3:1] (RAR, RAL, BSW) onto the rotate unit OP code.
// Purely combinational so the instruction decoder can reuse it directly.
module opr1_rotop_decode
    import opr_pkg::*;
(
    input  logic [2:0] ir_rot_i,   // {RAR, RAL, BSW}
    output logic [2:0] rot_op_o
);

    logic rar;
    logic ral;
    logic bsw;

    assign rar = ir_rot_i[2];
    assign ral = ir_rot_i[1];
    assign bsw = ir_rot_i[0];

    // Select the rotate unit operation; RAR and RAL together is defined as no rotate.
    always_comb begin
        // NOTE: default assignment first so every path drives rot_op_o and no latch is inferred.
        rot_op_o = ROT_NONE;
        if (rar && ral) begin
            rot_op_o = ROT_NONE;
        end else if (ral) begin
            rot_op_o = bsw ? ROT_RTL : ROT_RAL;
        end else if (rar) begin
            rot_op_o = bsw ? ROT_RTR : ROT_RAR;
        end else if (bsw) begin
            rot_op_o = ROT_SWAP;
        end
    end

endmodule

// File: rtl/opr1_sequencer.sv
// Multi-cycle sequencer for PDP-8 OPR Group 1 microinstructions. Walks the
// fixed phase order clear -> complement -> increment -> rotate, hands the
// rotate phase to the external combinational rotate unit, and returns the
// updated AC/Link with a one-cycle write strobe.
module opr1_sequencer
    import opr_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [WORD_W-1:0] IR,
    input  logic [WORD_W-1:0] ACI,
    input  logic              LI,
    output logic [2:0]        ROT_OP,
    output logic              ROT_OE,
    output logic [WORD_W-1:0] ROT_AC,
    output logic              ROT_L,
    input  logic [WORD_W-1:0] ROT_AO,
    input  logic              ROT_LO,
    output logic              BUSY,
    output logic              DONE,
    output logic              WE,
    output logic [WORD_W-1:0] ACO,
    output logic              LO
);

    state_e            state_q;
    logic [7:0]        ir_q;
    logic [WORD_W-1:0] ac_q;
    logic              l_q;
    logic [WORD_W-1:0] ac_d;
    logic              l_d;

    logic [2:0]        rot_op_q;
    logic              rot_oe_q;
    logic              busy_q;
    logic              done_q;
    logic [WORD_W-1:0] aco_q;
    logic              lo_q;

    logic              start_ok;
    logic [2:0]        rot_op_dec;
    logic [WORD_W:0]   inc_sum;

    // A request is taken only from IDLE and only for a Group 1 word.
    assign start_ok = START && (state_q == ST_IDLE) && is_opr1(IR);

    // Increment over AC alone; the carry out of bit 11 toggles the Link.
    assign inc_sum = {1'b0, ac_q} + {{WORD_W{1'b0}}, 1'b1};

    opr1_rotop_decode u_rotop_decode (
        .ir_rot_i (ir_q[IR_RAR:IR_BSW]),
        .rot_op_o (rot_op_dec)
    );

    // Next working AC/Link for the phase currently executing.
    always_comb begin
        ac_d = ac_q;
        l_d  = l_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    ac_d = ACI;
                    l_d  = LI;
                end
            end
            ST_T1: begin
                if (ir_q[IR_CLA]) ac_d = '0;
                if (ir_q[IR_CLL]) l_d  = 1'b0;
            end
            ST_T2: begin
                if (ir_q[IR_CMA]) ac_d = ~ac_q;
                if (ir_q[IR_CML]) l_d  = ~l_q;
            end
            ST_T3: begin
                if (ir_q[IR_IAC]) begin
                    ac_d = inc_sum[WORD_W-1:0];
                    l_d  = l_q ^ inc_sum[WORD_W];
                end
            end
            ST_T4: begin
                ac_d = ROT_AO;
                l_d  = ROT_LO;
            end
            default: begin
                ac_d = ac_q;
                l_d  = l_q;
            end
        endcase
    end

    // Phase sequencing with registered handshake, rotate-unit control and result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            ac_q     <= '0;
            l_q      <= 1'b0;
            rot_op_q <= ROT_NONE;
            rot_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            aco_q    <= '0;
            lo_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ac_q <= ac_d;
            l_q  <= l_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        ir_q    <= IR[7:0];
                        busy_q  <= 1'b1;
                        state_q <= ST_T1;
                    end
                end
                ST_T1: state_q <= ST_T2;
                ST_T2: state_q <= ST_T3;
                ST_T3: begin
                    // Rotate control is registered so it is stable for all of T4.
                    rot_op_q <= rot_op_dec;
                    rot_oe_q <= 1'b1;
                    state_q  <= ST_T4;
                end
                ST_T4: begin
                    rot_op_q <= ROT_NONE;
                    rot_oe_q <= 1'b0;
                    // Result captured together with the working regs so it is
                    // already valid while DONE/WE are high in DN.
                    aco_q    <= ac_d;
                    lo_q     <= l_d;
                    done_q   <= 1'b1;
                    state_q  <= ST_DN;
                end
                ST_DN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    rot_op_q <= ROT_NONE;
                    rot_oe_q <= 1'b0;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ROT_OP = rot_op_q;
    assign ROT_OE = rot_oe_q;
    assign ROT_AC = ac_q;
    assign ROT_L  = l_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign WE     = done_q;
    assign ACO    = aco_q;
    assign LO     = lo_q;

endmodule

// File: tb/tb_opr1_sequencer.sv
// Self-checking bench for opr1_sequencer: directed cases, protocol/reset
// cases and randomized OPR1 words against a whole-instruction reference model.
module tb_opr1_sequencer;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [11:0] IR;
    logic [11:0] ACI;
    logic        LI;
    logic [2:0]  ROT_OP;
    logic        ROT_OE;
    logic [11:0] ROT_AC;
    logic        ROT_L;
    logic [11:0] ROT_AO;
    logic        ROT_LO;
    logic        BUSY;
    logic        DONE;
    logic        WE;
    logic [11:0] ACO;
    logic        LO;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [11:0] last_aco;
    logic        last_lo;

    opr1_sequencer dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .IR     (IR),
        .ACI    (ACI),
        .LI     (LI),
        .ROT_OP (ROT_OP),
        .ROT_OE (ROT_OE),
        .ROT_AC (ROT_AC),
        .ROT_L  (ROT_L),
        .ROT_AO (ROT_AO),
        .ROT_LO (ROT_LO),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .WE     (WE),
        .ACO    (ACO),
        .LO     (LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Combinational rotate/swap unit; outputs zero when not enabled.
    always_comb begin
        ROT_AO = 12'o0000;
        ROT_LO = 1'b0;
        if (ROT_OE) begin
            case (ROT_OP)
                3'b001:  {ROT_LO, ROT_AO} = {ROT_L, ROT_AC[5:0], ROT_AC[11:6]};
                3'b010:  {ROT_LO, ROT_AO} = {ROT_AC, ROT_L};
                3'b011:  {ROT_LO, ROT_AO} = {ROT_AC[10:0], ROT_L, ROT_AC[11]};
                3'b100:  {ROT_LO, ROT_AO} = {ROT_AC[0], ROT_L, ROT_AC[11:1]};
                3'b101:  {ROT_LO, ROT_AO} = {ROT_AC[1:0], ROT_L, ROT_AC[11:2]};
                default: {ROT_LO, ROT_AO} = {ROT_L, ROT_AC};
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    // Whole-instruction model on the 13-bit {L,AC} value as a plain integer.
    task automatic ref_model(input logic [11:0] ir, input logic [11:0] ac, input logic l,
                             output logic [11:0] pre_ac, output logic pre_l,
                             output logic [11:0] res_ac, output logic res_l,
                             output logic [2:0] exp_op);
        int unsigned v;
        int unsigned a;
        int n;
        v = (l ? 4096 : 0) + ac;
        if (ir[7]) v = v & 4096;
        if (ir[6]) v = v & 4095;
        if (ir[5]) v = v ^ 4095;
        if (ir[4]) v = v ^ 4096;
        if (ir[0]) v = (v + 1) % 8192;
        pre_ac = v[11:0];
        pre_l  = v[12];
        n = ir[1] ? 2 : 1;
        exp_op = 3'd0;
        if (ir[3] && ir[2]) begin
            exp_op = 3'd0;
        end else if (ir[2]) begin
            v = ((v << n) | (v >> (13 - n))) % 8192;
            exp_op = ir[1] ? 3'd3 : 3'd2;
        end else if (ir[3]) begin
            v = ((v >> n) | (v << (13 - n))) % 8192;
            exp_op = ir[1] ? 3'd5 : 3'd4;
        end else if (ir[1]) begin
            a = v % 4096;
            v = (v & 4096) | ((a % 64) * 64 + a / 64);
            exp_op = 3'd1;
        end
        res_ac = v[11:0];
        res_l  = v[12];
    endtask

    // One complete operation; optionally pulses a second START in cycle inject_k.
    task automatic run_op(input string name, input logic [11:0] ir, input logic [11:0] ac,
                          input logic l, input int inject_k);
        logic [11:0] pre_ac, res_ac;
        logic        pre_l, res_l;
        logic [2:0]  exp_op;
        ref_model(ir, ac, l, pre_ac, pre_l, res_ac, res_l, exp_op);
        @(negedge CLK);
        START = 1'b1; IR = ir; ACI = ac; LI = l;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            START = 1'b0;
            check($sformatf("%s busy c%0d", name, k), BUSY, (k <= 5));
            check($sformatf("%s done c%0d", name, k), DONE, (k == 5));
            check($sformatf("%s we c%0d", name, k), WE, (k == 5));
            check($sformatf("%s rot_oe c%0d", name, k), ROT_OE, (k == 4));
            check($sformatf("%s rot_op c%0d", name, k), ROT_OP, (k == 4) ? exp_op : 3'd0);
            if (k == 1) begin
                check($sformatf("%s rot_ac t1", name), ROT_AC, ac);
                check($sformatf("%s rot_l t1", name), ROT_L, l);
            end
            if (k == 4) begin
                check($sformatf("%s rot_ac t4", name), ROT_AC, pre_ac);
                check($sformatf("%s rot_l t4", name), ROT_L, pre_l);
            end
            if (k >= 5) begin
                check($sformatf("%s aco c%0d", name, k), ACO, res_ac);
                check($sformatf("%s lo c%0d", name, k), LO, res_l);
            end
            if (k == inject_k) begin
                START = 1'b1; IR = 12'o7200; ACI = ~ac; LI = ~l;
            end
        end
        START = 1'b0;
        last_aco = res_ac;
        last_lo  = res_l;
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; IR = '0; ACI = '0; LI = 1'b0;
        last_aco = '0; last_lo = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        check("reset busy", BUSY, 0);
        check("reset done", DONE, 0);
        check("reset we", WE, 0);
        check("reset rot_oe", ROT_OE, 0);
        check("reset rot_op", ROT_OP, 0);
        check("reset aco", ACO, 0);
        check("reset lo", LO, 0);
        check("reset rot_ac", ROT_AC, 0);
        check("reset rot_l", ROT_L, 0);

        // Directed cases.
        run_op("iac", 12'o7001, 12'o1234, 1'b0, 0);
        check("iac aco const", ACO, 12'o1235);
        run_op("iac_wrap", 12'o7001, 12'o7777, 1'b0, 0);
        check("iac_wrap aco const", ACO, 12'o0000);
        check("iac_wrap lo const", LO, 1'b1);
        run_op("clr_cmp", 12'o7360, 12'o1234, 1'b0, 0);
        check("clr_cmp aco const", ACO, 12'o7777);
        check("clr_cmp lo const", LO, 1'b1);
        run_op("ral", 12'o7004, 12'o4000, 1'b0, 0);
        check("ral lo const", LO, 1'b1);
        run_op("bsw", 12'o7002, 12'o1234, 1'b1, 0);
        check("bsw aco const", ACO, 12'o3412);
        run_op("rtr", 12'o7012, 12'o0001, 1'b0, 0);
        check("rtr aco const", ACO, 12'o4000);
        run_op("cla_iac_ral", 12'o7205, 12'o5555, 1'b0, 0);
        check("cla_iac_ral aco const", ACO, 12'o0002);
        run_op("rar_ral", 12'o7014, 12'o2525, 1'b1, 0);
        check("rar_ral aco const", ACO, 12'o2525);
        check("rar_ral lo const", LO, 1'b1);

        // Non-OPR1 word is ignored.
        @(negedge CLK);
        START = 1'b1; IR = 12'o5000; ACI = 12'o1111; LI = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("ignored busy c%0d", k), BUSY, 0);
            check($sformatf("ignored done c%0d", k), DONE, 0);
            check($sformatf("ignored aco c%0d", k), ACO, last_aco);
            @(negedge CLK);
        end

        // Second START during T2 is ignored; run_op checks there is no extra DONE.
        run_op("restart_t2", 12'o7041, 12'o0777, 1'b0, 2);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            check($sformatf("restart_t2 idle busy c%0d", k), BUSY, 0);
            check($sformatf("restart_t2 idle done c%0d", k), DONE, 0);
        end

        // RESET during T3 aborts without DONE and clears the result.
        @(negedge CLK);
        START = 1'b1; IR = 12'o7001; ACI = 12'o1234; LI = 1'b1;
        @(negedge CLK);               // T1
        START = 1'b0;
        @(negedge CLK);               // T2
        @(negedge CLK);               // T3
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort busy", BUSY, 0);
        check("abort done", DONE, 0);
        check("abort we", WE, 0);
        check("abort rot_oe", ROT_OE, 0);
        check("abort aco", ACO, 0);
        check("abort lo", LO, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            check($sformatf("abort no done c%0d", k), DONE, 0);
            check($sformatf("abort no busy c%0d", k), BUSY, 0);
        end
        run_op("after_abort", 12'o7001, 12'o1234, 1'b0, 0);

        // Randomized Group 1 words.
        for (int i = 0; i < 40; i++) begin
            logic [11:0] r_ir;
            logic [11:0] r_ac;
            logic        r_l;
            r_ir = {4'b1110, 8'($urandom_range(0, 255))};
            r_ac = 12'($urandom_range(0, 4095));
            r_l  = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d_ir%0o_ac%0o_l%0d", i, r_ir, r_ac, r_l), r_ir, r_ac, r_l, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
